arbitro_rtc: RTL and testbench

ARBITRO_RTC -- requirements
Module: arbitro_rtc

---
 rtl/arbitro_rtc.sv | 222 ++++++++++++++++++++++
 tb/tb_arbitro_rtc.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rtc.sv
// -----------------------------------------------------------------------------
// arbitro_rtc
// Arbiter between three RTC transaction requesters (init, write, read).
// It grants one requester at a time and sequences the frame address and index
// for the external handshake generator. A watchdog aborts a transaction when
// the frame-end pulses stop arriving.
//
// Ports
//   reloj       : clock, rising edge
//   resetM      : asynchronous reset, active low
//   req_ini     : init request (level, highest priority)
//   req_esc     : time/date write request (level)
//   req_lec     : time/date read request (level)
//   fin_trama   : one-cycle end-of-frame pulse from the handshake generator
//   Control     : operation code 2'b10 init, 2'b00 write, 2'b01 read
//   sync        : 1 = handshake generator held in reset
//   direccion   : RTC register address of the current frame
//   indice      : frame index within the current transaction
//   gnt         : one-hot grant {ini, esc, lec}
//   ack         : one-cycle completion pulse {ini, esc, lec}
//   ocupado     : 1 while a transaction is in progress
//   error       : one-cycle pulse when the watchdog aborts a transaction
// -----------------------------------------------------------------------------
module arbitro_rtc #(
   parameter int unsigned N_INI      = 4,
   parameter int unsigned N_ESC      = 9,
   parameter int unsigned N_LEC      = 9,
   parameter logic [7:0]  DIR_INI    = 8'h00,
   parameter logic [7:0]  DIR_TIEMPO = 8'h21,
   parameter int unsigned T_MAX      = 64
) (
   input  logic       reloj,
   input  logic       resetM,
   input  logic       req_ini,
   input  logic       req_esc,
   input  logic       req_lec,
   input  logic       fin_trama,
   output logic [1:0] Control,
   output logic       sync,
   output logic [7:0] direccion,
   output logic [3:0] indice,
   output logic [2:0] gnt,
   output logic [2:0] ack,
   output logic       ocupado,
   output logic       error
);

   localparam int unsigned     WD_W    = $clog2(T_MAX + 1);
   localparam logic [WD_W-1:0] WD_LIM  = WD_W'(T_MAX - 1);
   localparam logic [WD_W-1:0] WD_SAT  = WD_W'(T_MAX);
   localparam logic [WD_W-1:0] WD_UNO  = WD_W'(1);
   localparam logic [3:0]      ULT_INI = 4'(N_INI - 1);
   localparam logic [3:0]      ULT_ESC = 4'(N_ESC - 1);
   localparam logic [3:0]      ULT_LEC = 4'(N_LEC - 1);
   localparam logic [1:0]      CTL_INI = 2'b10;
   localparam logic [1:0]      CTL_ESC = 2'b00;
   localparam logic [1:0]      CTL_LEC = 2'b01;

   typedef enum logic [1:0] {
      INACTIVO = 2'd0,
      ARRANQUE = 2'd1,
      TRAMA    = 2'd2,
      FIN      = 2'd3
   } estado_t;

   estado_t         estado_q, estado_d;
   logic [1:0]      control_q, control_d;
   logic            sync_q, sync_d;
   logic [7:0]      dir_q, dir_d;
   logic [3:0]      indice_q, indice_d;
   logic [2:0]      gnt_q, gnt_d;
   logic [2:0]      ack_q, ack_d;
   logic            ocupado_q, ocupado_d;
   logic            error_q, error_d;
   logic [WD_W-1:0] wd_q, wd_d;
   // 1 = write served most recently, 0 = read served most recently
   logic            hist_q, hist_d;
   logic [3:0]      ultimo_s;

   // Index of the last frame for the requester currently granted
   always_comb begin
      ultimo_s = ULT_LEC;
      case (gnt_q)
         3'b100:  ultimo_s = ULT_INI;
         3'b010:  ultimo_s = ULT_ESC;
         default: ultimo_s = ULT_LEC;
      endcase
   end

   // Next-state and next-output logic of the arbitration FSM
   always_comb begin
      estado_d  = estado_q;
      control_d = control_q;
      sync_d    = sync_q;
      dir_d     = dir_q;
      indice_d  = indice_q;
      gnt_d     = gnt_q;
      ack_d     = 3'b000;
      ocupado_d = ocupado_q;
      error_d   = 1'b0;
      wd_d      = wd_q;
      hist_d    = hist_q;
      case (estado_q)
         INACTIVO: begin
            sync_d    = 1'b1;
            gnt_d     = 3'b000;
            ocupado_d = 1'b0;
            if (req_ini) begin
               estado_d  = ARRANQUE;
               gnt_d     = 3'b100;
               control_d = CTL_INI;
               dir_d     = DIR_INI;
               indice_d  = 4'd0;
               ocupado_d = 1'b1;
            end else if (req_esc && (!req_lec || !hist_q)) begin
               // Write wins alone, or on a tie when read was served last
               estado_d  = ARRANQUE;
               gnt_d     = 3'b010;
               control_d = CTL_ESC;
               dir_d     = DIR_TIEMPO;
               indice_d  = 4'd0;
               ocupado_d = 1'b1;
               hist_d    = 1'b1;
            end else if (req_lec) begin
               estado_d  = ARRANQUE;
               gnt_d     = 3'b001;
               control_d = CTL_LEC;
               dir_d     = DIR_TIEMPO;
               indice_d  = 4'd0;
               ocupado_d = 1'b1;
               hist_d    = 1'b0;
            end else begin
               estado_d = INACTIVO;
            end
         end
         ARRANQUE: begin
            // Release the generator; the first frame starts next cycle
            estado_d = TRAMA;
            sync_d   = 1'b0;
            wd_d     = {WD_W{1'b0}};
         end
         TRAMA: begin
            if (fin_trama) begin
               // A frame end always beats a simultaneous watchdog expiry
               wd_d = {WD_W{1'b0}};
               if (indice_q == ultimo_s) begin
                  estado_d = FIN;
                  sync_d   = 1'b1;
                  ack_d    = gnt_q;
                  gnt_d    = 3'b000;
               end else begin
                  indice_d = indice_q + 4'd1;
                  dir_d    = dir_q + 8'd1;
               end
            end else if (wd_q == WD_LIM) begin
               // Counter reaches T_MAX on this edge: abort without ack
               estado_d = FIN;
               sync_d   = 1'b1;
               error_d  = 1'b1;
               gnt_d    = 3'b000;
               wd_d     = WD_SAT;
            end else if (wd_q != WD_SAT) begin
               wd_d = wd_q + WD_UNO;
            end else begin
               wd_d = wd_q;
            end
         end
         FIN: begin
            estado_d  = INACTIVO;
            sync_d    = 1'b1;
            ocupado_d = 1'b0;
            wd_d      = {WD_W{1'b0}};
         end
         default: begin
            estado_d  = INACTIVO;
            sync_d    = 1'b1;
            gnt_d     = 3'b000;
            ocupado_d = 1'b0;
            wd_d      = {WD_W{1'b0}};
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge reloj or negedge resetM) begin
      if (!resetM) begin
         estado_q  <= INACTIVO;
         control_q <= CTL_LEC;
         sync_q    <= 1'b1;
         dir_q     <= 8'h00;
         indice_q  <= 4'd0;
         gnt_q     <= 3'b000;
         ack_q     <= 3'b000;
         ocupado_q <= 1'b0;
         error_q   <= 1'b0;
         wd_q      <= {WD_W{1'b0}};
         hist_q    <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         control_q <= control_d;
         sync_q    <= sync_d;
         dir_q     <= dir_d;
         indice_q  <= indice_d;
         gnt_q     <= gnt_d;
         ack_q     <= ack_d;
         ocupado_q <= ocupado_d;
         error_q   <= error_d;
         wd_q      <= wd_d;
         hist_q    <= hist_d;
      end
   end

   assign Control   = control_q;
   assign sync      = sync_q;
   assign direccion = dir_q;
   assign indice    = indice_q;
   assign gnt       = gnt_q;
   assign ack       = ack_q;
   assign ocupado   = ocupado_q;
   assign error     = error_q;

endmodule

// File: tb/tb_arbitro_rtc.sv
// -----------------------------------------------------------------------------
// tb_arbitro_rtc
// Scoreboard bench for arbitro_rtc. Each request pushes an expected
// transaction record; the monitor pops it when the DUT grants and checks the
// grant, frames, completion and idle state. A second instance with a wrapping
// base address checks the 8-bit address rollover.
// -----------------------------------------------------------------------------
module tb_arbitro_rtc;

   localparam int T_MAX = 64;

   typedef struct packed {
      logic [2:0] g;
      logic [1:0] c;
      logic [7:0] b;
      logic [4:0] n;
      logic       err;
      logic       b2b;
   } txn_t;

   logic       reloj;
   logic       resetM;
   logic       req_ini, req_esc, req_lec, fin_trama;
   logic [1:0] Control;
   logic       sync;
   logic [7:0] direccion;
   logic [3:0] indice;
   logic [2:0] gnt, ack;
   logic       ocupado, error;

   logic       zero2, req2, fin2;
   logic [1:0] ctl2;
   logic       sync2, ocu2, err2;
   logic [7:0] dir2;
   logic [3:0] idx2;
   logic [2:0] gnt2, ack2;

   txn_t       sb_q[$];
   logic [7:0] exp2_q[$];
   txn_t       cur = '0;
   int         n_vec = 0;
   int         n_err = 0;
   int         gen_period = 32;
   int         gen_limit = 16;
   int         frames_tot = 0;
   int         hold_n = 0;
   int         done_cnt = 0;
   int         exp_done = 0;
   time        last_fin_t = 0;
   time        done_t = 0;
   logic       cur_act = 1'b0;
   logic       pend_idle = 1'b0;
   logic [2:0] prev_g = 3'b000;

   arbitro_rtc u_dut (
      .reloj(reloj), .resetM(resetM),
      .req_ini(req_ini), .req_esc(req_esc), .req_lec(req_lec),
      .fin_trama(fin_trama),
      .Control(Control), .sync(sync), .direccion(direccion), .indice(indice),
      .gnt(gnt), .ack(ack), .ocupado(ocupado), .error(error)
   );

   arbitro_rtc #(.DIR_TIEMPO(8'hFE), .N_LEC(3)) u_dut2 (
      .reloj(reloj), .resetM(resetM),
      .req_ini(zero2), .req_esc(zero2), .req_lec(req2),
      .fin_trama(fin2),
      .Control(ctl2), .sync(sync2), .direccion(dir2), .indice(idx2),
      .gnt(gnt2), .ack(ack2), .ocupado(ocu2), .error(err2)
   );

   initial begin
      reloj = 1'b0;
      forever #5 reloj = ~reloj;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic txn_t mk(input logic [2:0] g, input logic [1:0] c, input logic [7:0] b,
                               input logic [4:0] n, input logic err, input logic b2b);
      txn_t t;
      t.g = g; t.c = c; t.b = b; t.n = n; t.err = err; t.b2b = b2b;
      return t;
   endfunction

   task automatic expect_txn(input txn_t t);
      sb_q.push_back(t);
      if (!t.err) exp_done++;
   endtask

   task automatic wait_done(input int target);
      int k;
      k = 0;
      while (done_cnt < target && k < 4000) begin
         @(negedge reloj);
         k++;
      end
      check_eq("done_timeout", 32'(done_cnt >= target), 32'd1);
   endtask

   // Handshake generator model: a fin_trama pulse every gen_period TRAMA cycles
   initial begin : gen
      int cnt;
      logic [7:0] edir;
      cnt = 0;
      fin_trama = 1'b0;
      forever begin
         @(negedge reloj);
         fin_trama = 1'b0;
         if (!resetM || sync) begin
            cnt = 0;
         end else begin
            cnt++;
            if (cnt >= gen_period) begin
               cnt = 0;
               if (frames_tot < gen_limit) begin
                  edir = cur.b + 8'(frames_tot);
                  check_eq("frm_dir", 32'(direccion), 32'(edir));
                  check_eq("frm_idx", 32'(indice), 32'(frames_tot));
                  check_eq("frm_gnt", 32'(gnt), 32'(cur.g));
                  fin_trama = 1'b1;
                  frames_tot++;
                  last_fin_t = $time;
               end
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each grant and checks completion
   initial begin : mon
      forever begin
         @(negedge reloj);
         if (!resetM) begin
            cur_act = 1'b0;
            pend_idle = 1'b0;
            prev_g = 3'b000;
         end else begin
            if (pend_idle) begin
               check_eq("ocupado_idle", 32'(ocupado), 32'd0);
               check_eq("ctl_hold", 32'(Control), 32'(cur.c));
               pend_idle = 1'b0;
            end
            if (gnt != 3'b000 && prev_g == 3'b000) begin
               if (sb_q.size() == 0) begin
                  check_eq("unexp_gnt", 32'(gnt), 32'd0);
               end else begin
                  cur = sb_q.pop_front();
                  cur_act = 1'b1;
                  frames_tot = 0;
                  check_eq("gnt", 32'(gnt), 32'(cur.g));
                  check_eq("ctl", 32'(Control), 32'(cur.c));
                  check_eq("dir0", 32'(direccion), 32'(cur.b));
                  check_eq("idx0", 32'(indice), 32'd0);
                  check_eq("ocup", 32'(ocupado), 32'd1);
                  check_eq("sync_arr", 32'(sync), 32'd1);
                  if (cur.b2b) check_eq("gap", 32'($time - done_t), 32'd20);
               end
            end
            if (ack != 3'b000 || error) begin
               if (!cur_act) begin
                  check_eq("spur_ack", {28'd0, ack, error}, 32'd0);
               end else begin
                  check_eq("ack", 32'(ack), cur.err ? 32'd0 : 32'(cur.g));
                  check_eq("err", 32'(error), 32'(cur.err));
                  check_eq("nfr", 32'(frames_tot), cur.err ? 32'(gen_limit) : 32'(cur.n));
                  check_eq("sync_fin", 32'(sync), 32'd1);
                  check_eq("gnt_fin", 32'(gnt), 32'd0);
                  // Error registers on the T_MAX-th edge after the one that sampled the last pulse
                  if (cur.err) check_eq("wd_lat", 32'($time - last_fin_t), 32'(10 * (T_MAX + 1)));
                  done_t = $time;
                  done_cnt++;
                  cur_act = 1'b0;
                  pend_idle = 1'b1;
                  if (hold_n > 1) begin
                     hold_n--;
                  end else if (hold_n == 1) begin
                     hold_n = 0;
                     req_ini = 1'b0; req_esc = 1'b0; req_lec = 1'b0;
                  end else begin
                     case (cur.g)
                        3'b100:  req_ini = 1'b0;
                        3'b010:  req_esc = 1'b0;
                        default: req_lec = 1'b0;
                     endcase
                  end
               end
            end
            prev_g = gnt;
         end
      end
   end

   initial begin : main
      int k;
      logic [7:0] e;
      resetM = 1'b0;
      req_ini = 1'b0; req_esc = 1'b0; req_lec = 1'b0;
      zero2 = 1'b0; req2 = 1'b0; fin2 = 1'b0;
      repeat (2) @(negedge reloj);
      check_eq("rst_ctl", 32'(Control), 32'd1);
      check_eq("rst_sync", 32'(sync), 32'd1);
      check_eq("rst_dir", 32'(direccion), 32'd0);
      check_eq("rst_idx", 32'(indice), 32'd0);
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_ack", 32'(ack), 32'd0);
      check_eq("rst_ocup", 32'(ocupado), 32'd0);
      check_eq("rst_err", 32'(error), 32'd0);
      resetM = 1'b1;

      // Single read: 9 frames from 8'h21
      expect_txn(mk(3'b001, 2'b01, 8'h21, 5'd9, 1'b0, 1'b0));
      req_lec = 1'b1;
      wait_done(exp_done);

      // All three at once: ini, then esc (tie, read served last), then lec
      expect_txn(mk(3'b100, 2'b10, 8'h00, 5'd4, 1'b0, 1'b0));
      expect_txn(mk(3'b010, 2'b00, 8'h21, 5'd9, 1'b0, 1'b1));
      expect_txn(mk(3'b001, 2'b01, 8'h21, 5'd9, 1'b0, 1'b1));
      @(negedge reloj);
      req_ini = 1'b1; req_esc = 1'b1; req_lec = 1'b1;
      wait_done(exp_done);

      // esc and lec held for four transactions: they alternate
      hold_n = 4;
      expect_txn(mk(3'b010, 2'b00, 8'h21, 5'd9, 1'b0, 1'b0));
      expect_txn(mk(3'b001, 2'b01, 8'h21, 5'd9, 1'b0, 1'b1));
      expect_txn(mk(3'b010, 2'b00, 8'h21, 5'd9, 1'b0, 1'b1));
      expect_txn(mk(3'b001, 2'b01, 8'h21, 5'd9, 1'b0, 1'b1));
      @(negedge reloj);
      req_esc = 1'b1; req_lec = 1'b1;
      wait_done(exp_done);

      // Frame end exactly at watchdog expiry: frame end wins, no error
      gen_period = T_MAX;
      expect_txn(mk(3'b010, 2'b00, 8'h21, 5'd9, 1'b0, 1'b0));
      @(negedge reloj);
      req_esc = 1'b1;
      wait_done(exp_done);

      // Generator stops after 3 frames of a write: watchdog abort
      gen_period = 32;
      gen_limit = 3;
      expect_txn(mk(3'b010, 2'b00, 8'h21, 5'd9, 1'b1, 1'b0));
      @(negedge reloj);
      req_esc = 1'b1;
      wait_done(done_cnt + 1);
      gen_limit = 16;
      expect_txn(mk(3'b001, 2'b01, 8'h21, 5'd9, 1'b0, 1'b0));
      @(negedge reloj);
      req_lec = 1'b1;
      wait_done(exp_done + 1);
      exp_done = done_cnt;

      // Reset at frame 5 of a read, then re-request from indice 0
      expect_txn(mk(3'b001, 2'b01, 8'h21, 5'd9, 1'b1, 1'b0));
      exp_done = done_cnt;
      @(negedge reloj);
      req_lec = 1'b1;
      k = 0;
      while (frames_tot < 5 && k < 1000) begin
         @(negedge reloj);
         k++;
      end
      check_eq("frm5_timeout", 32'(frames_tot >= 5), 32'd1);
      #2 resetM = 1'b0;
      #1;
      check_eq("mid_ctl", 32'(Control), 32'd1);
      check_eq("mid_sync", 32'(sync), 32'd1);
      check_eq("mid_dir", 32'(direccion), 32'd0);
      check_eq("mid_idx", 32'(indice), 32'd0);
      check_eq("mid_gnt", 32'(gnt), 32'd0);
      check_eq("mid_ocup", 32'(ocupado), 32'd0);
      check_eq("mid_ack_err", {28'd0, ack, error}, 32'd0);
      repeat (3) @(negedge reloj);
      void'(sb_q.pop_front());
      expect_txn(mk(3'b001, 2'b01, 8'h21, 5'd9, 1'b0, 1'b0));
      resetM = 1'b1;
      @(negedge reloj);
      check_eq("regrant", 32'(gnt), 32'd1);
      wait_done(exp_done);

      // Second instance: fin_trama ignored while idle, then address wrap
      fin2 = 1'b1;
      @(negedge reloj);
      fin2 = 1'b0;
      @(negedge reloj);
      check_eq("idle_fin", 32'(idx2), 32'd0);
      for (int i = 0; i < 3; i++) exp2_q.push_back(8'hFE + 8'(i));
      req2 = 1'b1;
      k = 0;
      while (gnt2 == 3'b000 && k < 10) begin
         @(negedge reloj);
         k++;
      end
      check_eq("gnt2", 32'(gnt2), 32'd1);
      for (int i = 0; i < 3; i++) begin
         repeat (4) @(negedge reloj);
         e = exp2_q.pop_front();
         check_eq("dir2", 32'(dir2), 32'(e));
         fin2 = 1'b1;
         @(negedge reloj);
         fin2 = 1'b0;
      end
      check_eq("ack2", 32'(ack2), 32'd1);
      req2 = 1'b0;
      repeat (3) @(negedge reloj);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
